// File: rtl/sram_1rw1r_responder.sv
// sram_1rw1r_responder
//   Flop-based stand-in for a 1rw1r SRAM macro that uses the OpenRAM-style port
//   protocol. After reset, a scrub sequencer zeroes every word, one word per
//   cycle. Commands are accepted only once that sequencer has finished.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   csb0    port 0 chip select, active low
//   web0    port 0 write enable, active low (1 = read)
//   wmask0  port 0 byte write mask, one bit per byte lane
//   addr0   port 0 word address
//   din0    port 0 write data
//   dout0   port 0 registered read data
//   csb1    port 1 (read-only) chip select, active low
//   addr1   port 1 word address
//   dout1   port 1 registered read data
//   ready   high once the scrub has completed
module sram_1rw1r_responder #(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csb0,
  input  logic              web0,
  input  logic [DW/8-1:0]   wmask0,
  input  logic [AW-1:0]     addr0,
  input  logic [DW-1:0]     din0,
  output logic [DW-1:0]     dout0,
  input  logic              csb1,
  input  logic [AW-1:0]     addr1,
  output logic [DW-1:0]     dout1,
  output logic              ready
);

  localparam int NB = DW / 8;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  localparam logic [0:0] SCRUB = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];

  // The address is compared at full width, so that out-of-range words never
  // alias onto the low index bits.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_V);
  endfunction

  logic [CW-1:0] idx0, idx1;
  logic          ok0, ok1, wr0, rd0, rd1;

  always_comb begin
    idx0 = addr0[CW-1:0];
    idx1 = addr1[CW-1:0];
    ok0  = in_range(addr0);
    ok1  = in_range(addr1);
    wr0  = (state == RUN) && !csb0 && !web0 && ok0;
    rd0  = (state == RUN) && !csb0 &&  web0;
    rd1  = (state == RUN) && !csb1;
  end

  // Scrub sequencer: one word per edge, then hand over to RUN permanently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCRUB;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == SCRUB) begin
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // The array is not reset; the scrub clears it instead. A write of a
  // masked-off lane leaves that byte untouched.
  always_ff @(posedge clk) begin
    if (state == SCRUB) begin
      mem[cnt] <= '0;
    end else if (wr0) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask0[i]) mem[idx0][8*i +: 8] <= din0[8*i +: 8];
      end
    end
  end

  // Read registers sample mem before this edge's write lands, so a port 1 read
  // that collides with a port 0 write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      if (rd0) dout0 <= ok0 ? mem[idx0] : '0;
      if (rd1) dout1 <= ok1 ? mem[idx1] : '0;
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_responder.sv
module tb_sram_1rw1r_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;
  logic        ready;

  int nvec = 0;
  int nerr = 0;

  sram_1rw1r_responder #(.DW(32), .AW(8), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1),
    .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  task automatic rd0(input logic [7:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = 4'h0;
    tick();
    csb0 = 1'b1;
  endtask

  task automatic rd1(input logic [7:0] a);
    csb1 = 1'b0; addr1 = a;
    tick();
    csb1 = 1'b1;
  endtask

  initial begin
    int n;
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_dout0", dout0, 32'h0);
    check("rst_dout1", dout1, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h0);

    // Release reset, then attempt a write and a read while the scrub runs.
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 5) begin
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd3; din0 = 32'hDEADBEEF; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 8'd3;
      end
      tick();
      if (i == 5) idle();
      check($sformatf("scrub_ready_%0d", i), {31'b0, ready}, (i == 32) ? 32'h1 : 32'h0);
      if (i == 5) begin
        check("scrub_dout0", dout0, 32'h0);
        check("scrub_dout1", dout1, 32'h0);
      end
    end

    for (int a = 0; a < 32; a++) begin
      rd1(8'(a));
      check($sformatf("zero_rd1_%0d", a), dout1, 32'h0);
    end
    rd0(8'd3);
    check("scrub_ignored_wr", dout0, 32'h0);

    // Byte-masked writes.
    wr0(8'd7, 32'h11223344, 4'b1111);
    wr0(8'd7, 32'hAABBCCDD, 4'b0101);
    rd0(8'd7);
    check("mask_rd7", dout0, 32'h11BB33DD);
    wr0(8'd7, 32'hFFFFFFFF, 4'b0000);
    check("wr_holds_dout0", dout0, 32'h11BB33DD);
    rd0(8'd7);
    check("mask0_noop", dout0, 32'h11BB33DD);
    wr0(8'd12, 32'hA5A5A5A5, 4'hF);
    rd0(8'd12);
    check("raw_next", dout0, 32'hA5A5A5A5);

    // Same-edge collision: port 1 sees pre-write data.
    wr0(8'd9, 32'h00000005, 4'hF);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd9; din0 = 32'h000000FF; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 8'd9;
    tick();
    csb0 = 1'b1; web0 = 1'b1;
    check("collide_old", dout1, 32'h00000005);
    tick();
    csb1 = 1'b1;
    check("collide_new", dout1, 32'h000000FF);

    // Out-of-range addresses.
    wr0(8'd40, 32'hCAFEF00D, 4'hF);
    rd0(8'd40);
    check("oor_rd40", dout0, 32'h0);
    rd0(8'd8);
    check("oor_noalias8", dout0, 32'h0);
    rd1(8'd40);
    check("oor_rd1_40", dout1, 32'h0);
    rd0(8'd7);
    check("hold_setup", dout0, 32'h11BB33DD);
    repeat (10) tick();
    check("hold_dout0", dout0, 32'h11BB33DD);
    check("hold_dout1", dout1, 32'h0);

    // Reset in the middle of activity.
    wr0(8'd2, 32'h12345678, 4'hF);
    rd0(8'd2);
    check("pre_rst_rd0", dout0, 32'h12345678);
    rd1(8'd2);
    check("pre_rst_rd1", dout1, 32'h12345678);
    #2 rst_n = 1'b0;
    #1;
    check("async_dout0", dout0, 32'h0);
    check("async_dout1", dout1, 32'h0);
    check("async_ready", {31'b0, ready}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    check("rescrub_cycles", 32'(n), 32'd32);
    rd0(8'd2);
    check("rescrub_rd2", dout0, 32'h0);
    rd1(8'd7);
    check("rescrub_rd7", dout1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
